spi_rr_sequencer: RTL and testbench

- Shares one spi_master between p_NUM_REQ requesters.
- Per transfer: picks a requester round-robin, asserts that requester's slave select, waits a setup gap, then pulses the master's i_dv with the latched word.
- Waits for o_active to fall, returns the received word, deasserts the slave select and enforces an inter-transfer gap.
- Sits between client logic and spi_master; drives spi_slave i_ss lines directly.

---
 rtl/spi_rr_sequencer_pkg.sv | 24 ++
 rtl/spi_rr_pick.sv | 35 +++
 rtl/spi_rr_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_spi_rr_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rr_sequencer_pkg.sv
// Shared definitions for the SPI round-robin sequencer: FSM encodings, default word length, helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_rr_sequencer_pkg;

   // Default SPI word length, kept equal to the spi_master/spi_slave default.
   localparam int SPI_WORD_LEN_DEF = 8;

   // Sequencer FSM states, 3-bit encodings shared with the SPI master/slave collateral.
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SETUP    = 3'd1,
      S_START    = 3'd2,
      S_WAIT_ACT = 3'd3,
      S_BUSY     = 3'd4,
      S_HOLD     = 3'd5
   } seq_state_t;

   // Larger of two integers, used to size the shared setup/hold counter.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping modulo p_NUM_REQ.
// Latency: combinational, zero cycles.
// Backpressure: none; the sequencer only samples the result while idle.
module spi_rr_pick #(
   parameter int p_NUM_REQ = 2,
   parameter int p_IDX_W   = $clog2(p_NUM_REQ)
) (
   input  logic [p_NUM_REQ-1:0] i_req,
   input  logic [p_IDX_W-1:0]   i_ptr,
   output logic [p_NUM_REQ-1:0] o_gnt,
   output logic [p_IDX_W-1:0]   o_idx,
   output logic                 o_vld
);

   logic [p_IDX_W-1:0] w_cand;

   // Scan from the farthest offset down to the pointer so the nearest set request is written last and wins.
   always_comb begin
      w_cand = '0;
      o_gnt  = '0;
      o_idx  = '0;
      o_vld  = 1'b0;
      for (int off = p_NUM_REQ - 1; off >= 0; off--) begin
         w_cand = p_IDX_W'((int'(i_ptr) + off) % p_NUM_REQ);
         if (i_req[w_cand]) begin
            o_idx = w_cand;
            o_vld = 1'b1;
         end
      end
      if (o_vld) begin
         o_gnt[o_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/spi_rr_sequencer.sv
// Shares one spi_master between p_NUM_REQ requesters, round-robin, driving per-requester slave selects.
// Latency: o_ack -> o_m_dv = p_SS_SETUP+1 cycles; o_done -> next o_ack >= p_SS_HOLD+1 cycles.
// Backpressure: requests hold i_req until o_ack; optional watchdog via `define SPI_SEQ_TIMEOUT_EN.
module spi_rr_sequencer
   import spi_rr_sequencer_pkg::*;
#(
   parameter int p_NUM_REQ  = 2,
   parameter int p_WORD_LEN = SPI_WORD_LEN_DEF,
   parameter int p_SS_SETUP = 4,
   parameter int p_SS_HOLD  = 4,
   parameter int p_TIMEOUT  = 1023
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [p_NUM_REQ-1:0]            i_req,
   input  logic [p_NUM_REQ*p_WORD_LEN-1:0] i_req_data,
   output logic [p_NUM_REQ-1:0]            o_ack,
   output logic [p_NUM_REQ-1:0]            o_done,
   output logic [p_NUM_REQ-1:0]            o_err,
   output logic [p_WORD_LEN-1:0]           o_rdata,
   output logic [p_WORD_LEN-1:0]           o_m_data,
   output logic                            o_m_dv,
   input  logic                            i_m_active,
   input  logic [p_WORD_LEN-1:0]           i_m_data,
   output logic [p_NUM_REQ-1:0]            o_ss,
   output logic                            o_busy
);

   localparam int lp_IDX_W = $clog2(p_NUM_REQ);
   localparam int lp_CNT_W = $clog2(max_int(p_SS_SETUP, p_SS_HOLD) + 1);

   // The counter is loaded with N-1 so a phase lasts exactly N cycles including the load edge's successor.
   localparam logic [lp_CNT_W-1:0] lp_SETUP_LD = lp_CNT_W'(p_SS_SETUP - 1);
   localparam logic [lp_CNT_W-1:0] lp_HOLD_LD  = lp_CNT_W'(p_SS_HOLD - 1);
   localparam logic [lp_IDX_W-1:0] lp_IDX_LAST = lp_IDX_W'(p_NUM_REQ - 1);

   // Reject configurations outside the supported range at elaboration time.
   if (p_NUM_REQ < 2 || p_NUM_REQ > 8 || p_SS_SETUP < 1 || p_SS_HOLD < 1 || p_TIMEOUT < 1) begin : g_param_check
      $error("spi_rr_sequencer: parameter out of range");
   end

   seq_state_t            r_state;
   logic [lp_CNT_W-1:0]   r_cnt;
   logic [lp_IDX_W-1:0]   r_ptr;
   logic [lp_IDX_W-1:0]   r_gnt_idx;
   logic [p_NUM_REQ-1:0]  r_ss;
   logic                  r_m_dv;
   logic [p_WORD_LEN-1:0] r_m_data;
   logic [p_WORD_LEN-1:0] r_rdata;
   logic [p_NUM_REQ-1:0]  r_ack;
   logic [p_NUM_REQ-1:0]  r_done;
   logic [p_NUM_REQ-1:0]  r_err;

   logic [p_NUM_REQ-1:0]  w_gnt;
   logic [lp_IDX_W-1:0]   w_idx;
   logic                  w_vld;
   logic [p_NUM_REQ-1:0]  w_cur_onehot;
   logic [lp_IDX_W-1:0]   w_ptr_next;
   logic                  w_wdog_hit;
   logic [p_WORD_LEN-1:0] w_slice [p_NUM_REQ];

   // Unpack the flat request-data bus into one word per requester.
   for (genvar k = 0; k < p_NUM_REQ; k++) begin : g_slice
      assign w_slice[k] = i_req_data[k*p_WORD_LEN +: p_WORD_LEN];
   end

   spi_rr_pick #(
      .p_NUM_REQ (p_NUM_REQ),
      .p_IDX_W   (lp_IDX_W)
   ) u_pick (
      .i_req (i_req),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_vld (w_vld)
   );

   // One-hot form of the requester currently owning the master, for done/err pulses.
   always_comb begin
      w_cur_onehot            = '0;
      w_cur_onehot[r_gnt_idx] = 1'b1;
   end

   // Pointer moves one past the requester just served so it cannot win twice in a row under contention.
   assign w_ptr_next = (r_gnt_idx == lp_IDX_LAST) ? '0 : r_gnt_idx + lp_IDX_W'(1);

`ifdef SPI_SEQ_TIMEOUT_EN
   localparam int                   lp_WDOG_W    = $clog2(p_TIMEOUT + 1);
   localparam logic [lp_WDOG_W-1:0] lp_WDOG_LAST = lp_WDOG_W'(p_TIMEOUT - 1);

   logic [lp_WDOG_W-1:0] r_wdog;
   logic                 w_in_xfer;

   assign w_in_xfer  = (r_state == S_WAIT_ACT) || (r_state == S_BUSY);
   assign w_wdog_hit = w_in_xfer && (r_wdog == lp_WDOG_LAST);

   // Count cycles spent waiting on the master; cleared whenever the transfer is not in flight.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wdog <= '0;
      end else if (w_in_xfer && !w_wdog_hit) begin
         r_wdog <= r_wdog + lp_WDOG_W'(1);
      end else begin
         r_wdog <= '0;
      end
   end
`else
   // Without the watchdog a stalled master holds the sequencer in WAIT_ACT/BUSY indefinitely.
   assign w_wdog_hit = 1'b0;
`endif

   // Main sequencer FSM with all outputs registered; pulses default low every cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_ptr     <= '0;
         r_gnt_idx <= '0;
         r_ss      <= '1;
         r_m_dv    <= 1'b0;
         r_m_data  <= '0;
         r_rdata   <= '0;
         r_ack     <= '0;
         r_done    <= '0;
         r_err     <= '0;
      end else begin
         r_ack  <= '0;
         r_done <= '0;
         r_err  <= '0;
         r_m_dv <= 1'b0;
         if (w_wdog_hit) begin
            // Master never finished: release the slave, report the abort, keep the rotation moving.
            r_err   <= w_cur_onehot;
            r_ss    <= '1;
            r_ptr   <= w_ptr_next;
            r_cnt   <= lp_HOLD_LD;
            r_state <= S_HOLD;
         end else begin
            case (r_state)
               S_IDLE: begin
                  // After a reset the master may still be shifting; only grant once it is quiet.
                  if (w_vld && !i_m_active) begin
                     r_gnt_idx <= w_idx;
                     r_m_data  <= w_slice[w_idx];
                     r_ack     <= w_gnt;
                     r_ss      <= ~w_gnt;
                     r_cnt     <= lp_SETUP_LD;
                     r_state   <= S_SETUP;
                  end
               end
               S_SETUP: begin
                  if (r_cnt == '0) begin
                     r_state <= S_START;
                  end else begin
                     r_cnt <= r_cnt - lp_CNT_W'(1);
                  end
               end
               S_START: begin
                  r_m_dv  <= 1'b1;
                  r_state <= S_WAIT_ACT;
               end
               S_WAIT_ACT: begin
                  if (i_m_active) begin
                     r_state <= S_BUSY;
                  end
               end
               S_BUSY: begin
                  if (!i_m_active) begin
                     r_rdata <= i_m_data;
                     r_done  <= w_cur_onehot;
                     r_ss    <= '1;
                     r_ptr   <= w_ptr_next;
                     r_cnt   <= lp_HOLD_LD;
                     r_state <= S_HOLD;
                  end
               end
               S_HOLD: begin
                  if (r_cnt == '0) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_cnt <= r_cnt - lp_CNT_W'(1);
                  end
               end
               default: begin
                  r_ss    <= '1;
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign o_ack    = r_ack;
   assign o_done   = r_done;
   assign o_err    = r_err;
   assign o_rdata  = r_rdata;
   assign o_m_data = r_m_data;
   assign o_m_dv   = r_m_dv;
   assign o_ss     = r_ss;
   assign o_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_rr_sequencer.sv
// Directed bench for spi_rr_sequencer: two instances (2 and 4 requesters) with behavioural SPI masters.
// Expected grants/words are queued when stimulus is driven and checked when the DUT acks/completes.
module tb_spi_rr_sequencer;

   typedef struct {
      int         idx;
      logic [7:0] tx;
      logic [7:0] rx;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- 2-requester instance ----------------
   logic [1:0]  req2;
   logic [15:0] data2;
   logic [1:0]  ack2, done2, err2, ss2;
   logic [7:0]  rdata2, mdata2, mrx2;
   logic        mdv2, mact2, busy2;

   spi_rr_sequencer #(.p_NUM_REQ(2)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_req(req2), .i_req_data(data2),
      .o_ack(ack2), .o_done(done2), .o_err(err2), .o_rdata(rdata2),
      .o_m_data(mdata2), .o_m_dv(mdv2), .i_m_active(mact2), .i_m_data(mrx2),
      .o_ss(ss2), .o_busy(busy2)
   );

   // ---------------- 4-requester instance ----------------
   logic [3:0]  req4;
   logic [31:0] data4;
   logic [3:0]  ack4, done4, err4, ss4;
   logic [7:0]  rdata4, mdata4, mrx4;
   logic        mdv4, mact4, busy4;

   spi_rr_sequencer #(.p_NUM_REQ(4)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_req(req4), .i_req_data(data4),
      .o_ack(ack4), .o_done(done4), .o_err(err4), .o_rdata(rdata4),
      .o_m_data(mdata4), .o_m_dv(mdv4), .i_m_active(mact4), .i_m_data(mrx4),
      .o_ss(ss4), .o_busy(busy4)
   );

   exp_t       q2[$];
   exp_t       q4[$];
   exp_t       cur2, cur4;
   bit         cur2_vld = 0;
   int         ack_cyc2 = 0, done_cyc2 = -1000;
   int         ack_cnt2 = 0, done_cnt2 = 0, dv_cnt2 = 0;
   int         ack_cnt4 = 0, done_cnt4 = 0;
   int         act_len2 = 12;
   logic [7:0] resp2 [2];
   logic [7:0] resp4 [4];
   logic [7:0] tx_seen2 = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int cnt_of(input int which);
      case (which)
         0: return ack_cnt2;
         1: return done_cnt2;
         2: return dv_cnt2;
         3: return ack_cnt4;
         default: return done_cnt4;
      endcase
   endfunction

   task automatic wait_for(input int which, input int n, input string tag);
      int i;
      i = 0;
      while (cnt_of(which) < n && i < 1000) begin
         @(negedge clk);
         i++;
      end
      chk(tag, cnt_of(which) >= n, 1);
   endtask

   // Behavioural master for dut2: goes active after i_dv, returns the selected slave's word.
   initial begin
      int sel;
      mact2 = 1'b0;
      mrx2  = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (mdv2 === 1'b1) begin
            sel = 0;
            for (int k = 0; k < 2; k++) if (ss2[k] === 1'b0) sel = k;
            tx_seen2 = mdata2;
            mact2    = 1'b1;
            repeat (act_len2) @(posedge clk);
            #1;
            mrx2  = resp2[sel];
            mact2 = 1'b0;
         end
      end
   end

   // Behavioural master for dut4.
   initial begin
      int sel;
      mact4 = 1'b0;
      mrx4  = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (mdv4 === 1'b1) begin
            sel = 0;
            for (int k = 0; k < 4; k++) if (ss4[k] === 1'b0) sel = k;
            mact4 = 1'b1;
            repeat (6) @(posedge clk);
            #1;
            mrx4  = resp4[sel];
            mact4 = 1'b0;
         end
      end
   end

   // Scoreboard monitor for dut2.
   initial begin
      logic [1:0] e_ss;
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            chk("ss2_at_most_one_low", $countones(~ss2) <= 1, 1);
            if (ack2 !== 2'b00) begin
               if (q2.size() == 0) begin
                  chk("ack2_unexpected", ack2, 0);
               end else begin
                  cur2     = q2.pop_front();
                  cur2_vld = 1;
                  chk("ack2_grant", ack2, 1 << cur2.idx);
                  chk("ack2_gap_after_done", (cyc - done_cyc2) >= 5, 1);
                  ack_cyc2 = cyc;
                  ack_cnt2++;
               end
            end
            if (mdv2 === 1'b1) begin
               e_ss = ~(2'b01 << cur2.idx);
               dv_cnt2++;
               chk("dv2_latency", cyc - ack_cyc2, 5);
               chk("dv2_mdata", mdata2, cur2.tx);
               chk("dv2_ss_low", ss2, e_ss);
            end
            if (done2 !== 2'b00) begin
               chk("done2_expected", cur2_vld, 1);
               chk("done2_onehot", done2, 1 << cur2.idx);
               chk("done2_rdata", rdata2, cur2.rx);
               chk("done2_tx_at_slave", tx_seen2, cur2.tx);
               chk("done2_ss_released", ss2, 2'b11);
               chk("done2_no_err", err2, 0);
               cur2_vld  = 0;
               done_cyc2 = cyc;
               done_cnt2++;
            end
         end
      end
   end

   // Scoreboard monitor for dut4.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            chk("ss4_at_most_one_low", $countones(~ss4) <= 1, 1);
            if (ack4 !== 4'b0000) begin
               if (q4.size() == 0) begin
                  chk("ack4_unexpected", ack4, 0);
               end else begin
                  cur4 = q4.pop_front();
                  chk("ack4_grant", ack4, 1 << cur4.idx);
                  ack_cnt4++;
               end
            end
            if (done4 !== 4'b0000) begin
               chk("done4_onehot", done4, 1 << cur4.idx);
               chk("done4_rdata", rdata4, cur4.rx);
               done_cnt4++;
            end
         end
      end
   end

   // Hard stop in case a wait loop is broken.
   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end

   // Directed stimulus.
   initial begin
      int last_act;
      int i;
      rst   = 1'b1;
      req2  = '0;
      data2 = '0;
      req4  = '0;
      data4 = '0;
      for (int k = 0; k < 2; k++) resp2[k] = 8'h00;
      for (int k = 0; k < 4; k++) resp4[k] = 8'h40 + 8'(k);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      chk("rst_ss2", ss2, 2'b11);
      chk("rst_ss4", ss4, 4'hF);
      chk("rst_mdv2", mdv2, 0);
      chk("rst_ack2", ack2, 0);
      chk("rst_done2", done2, 0);
      chk("rst_rdata2", rdata2, 0);
      chk("rst_mdata2", mdata2, 0);
      chk("rst_busy2", busy2, 0);

      // Contention: both held, strict alternation 0,1,0,1
      resp2[0] = 8'h11;
      resp2[1] = 8'h22;
      data2    = {8'h3C, 8'hA5};
      q2.push_back('{0, 8'hA5, 8'h11});
      q2.push_back('{1, 8'h3C, 8'h22});
      q2.push_back('{0, 8'hA5, 8'h11});
      q2.push_back('{1, 8'h3C, 8'h22});
      req2 = 2'b11;
      wait_for(0, 4, "contention_acks");
      req2 = 2'b00;
      wait_for(1, 4, "contention_dones");

      // Single request from requester 0
      resp2[0] = 8'h69;
      data2    = {8'h3C, 8'hF0};
      q2.push_back('{0, 8'hF0, 8'h69});
      req2 = 2'b01;
      wait_for(0, 5, "single_ack");
      req2 = 2'b00;
      wait_for(1, 5, "single_done");

      // Late request: requester 1 rises while requester 0 is in BUSY
      resp2[0] = 8'hC4;
      data2    = {8'h3C, 8'h5B};
      q2.push_back('{0, 8'h5B, 8'hC4});
      req2 = 2'b01;
      wait_for(0, 6, "late_first_ack");
      req2 = 2'b00;
      i = 0;
      while (mact2 !== 1'b1 && i < 100) begin
         @(negedge clk);
         i++;
      end
      chk("late_master_active", mact2, 1);
      resp2[1] = 8'h9D;
      data2    = {8'hE7, 8'h5B};
      q2.push_back('{1, 8'hE7, 8'h9D});
      req2 = 2'b10;
      wait_for(1, 6, "late_first_done");
      chk("late_no_ack_during_busy", ack_cnt2, 6);
      wait_for(0, 7, "late_second_ack");
      chk("late_ack_after_hold", ack_cyc2 - done_cyc2, 5);
      req2 = 2'b00;
      wait_for(1, 7, "late_second_done");

      // Reset in the middle of BUSY
      act_len2 = 80;
      resp2[0] = 8'hEE;
      data2    = {8'hE7, 8'h77};
      q2.push_back('{0, 8'h77, 8'hEE});
      req2 = 2'b01;
      wait_for(0, 8, "rstbusy_ack");
      req2 = 2'b00;
      wait_for(2, 8, "rstbusy_dv");
      repeat (40) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rstbusy_ss_async", ss2, 2'b11);
      chk("rstbusy_mdv", mdv2, 0);
      chk("rstbusy_busy", busy2, 0);
      chk("rstbusy_rdata", rdata2, 0);
      chk("rstbusy_master_still_active", mact2, 1);
      cur2_vld = 0;
      @(negedge clk);
      rst      = 1'b0;
      act_len2 = 12;
      resp2[1] = 8'hB2;
      data2    = {8'h4D, 8'h77};
      q2.push_back('{1, 8'h4D, 8'hB2});
      req2     = 2'b10;
      last_act = cyc;
      i = 0;
      while (ack_cnt2 < 9 && i < 300) begin
         @(negedge clk);
         if (ack_cnt2 < 9 && mact2 === 1'b1) last_act = cyc;
         i++;
      end
      chk("rstbusy_next_ack", ack_cnt2, 9);
      chk("rstbusy_ack_after_inactive", ack_cyc2 > last_act, 1);
      chk("rstbusy_no_done", done_cnt2, 7);
      req2 = 2'b00;
      wait_for(1, 8, "rstbusy_next_done");

      // Fairness on 4 requesters: 0 and 3 held -> 0,3,0,3 with pointer wrap 3->0
      data4 = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      q4.push_back('{0, 8'hA0, 8'h40});
      q4.push_back('{3, 8'hD3, 8'h43});
      q4.push_back('{0, 8'hA0, 8'h40});
      q4.push_back('{3, 8'hD3, 8'h43});
      req4 = 4'b1001;
      wait_for(3, 4, "fair_acks");
      req4 = 4'b0000;
      wait_for(4, 4, "fair_dones");
      // Pointer is back at 0 after serving 3: requests 1 and 2 -> 1 wins
      q4.push_back('{1, 8'hB1, 8'h41});
      req4 = 4'b0110;
      wait_for(3, 5, "fair_wrap_ack");
      req4 = 4'b0000;
      wait_for(4, 5, "fair_wrap_done");
      chk("fair_no_err", err4, 0);

      repeat (5) @(negedge clk);
      chk("queue2_drained", q2.size(), 0);
      chk("queue4_drained", q4.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
